// File: rtl/register_access_controller_pkg.sv
// Shared types and constants for the register access controller.
// Holds the sequencer state encoding and the architectural register indices.
package register_access_controller_pkg;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      READ_1,
      READ_2,
      DONE
   } state_t;

   localparam int REGISTER_COUNT      = 32;
   localparam int STACK_POINTER_INDEX = 2;
   localparam int ZERO_REGISTER       = 0;

endpackage

// File: rtl/register_access_controller_operand_bypass.sv
// Operand select for one read slot: x0 reads as zero, and a same-cycle
// writeback to the indexed register wins over the register file output.
module operand_bypass
   import register_access_controller_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic [ADDRESS_WIDTH-1:0] index,
   input  logic [DATA_WIDTH-1:0]    rf_read_data,
   input  logic                     wb_valid,
   input  logic [ADDRESS_WIDTH-1:0] wb_address,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   output logic [DATA_WIDTH-1:0]    operand
);

   always_comb begin
      if (index == ADDRESS_WIDTH'(ZERO_REGISTER)) begin
         operand = '0;
      end else if (wb_valid && (wb_address == index)) begin
         operand = wb_data;
      end else begin
         operand = rf_read_data;
      end
   end

endmodule

// File: rtl/register_access_controller.sv
// Sequences rs1/rs2 reads over a single register file read port and, after
// reset, walks x1..x31 so the register file array itself needs no reset.
module register_access_controller
   import register_access_controller_pkg::*;
#(
   parameter int               DATA_WIDTH    = 32,
   parameter int               ADDRESS_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] SP_INIT  = 32'h0000_0000
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     init_done,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDRESS_WIDTH-1:0] req_rs1,
   input  logic [ADDRESS_WIDTH-1:0] req_rs2,
   input  logic                     req_use_rs2,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_WIDTH-1:0]    resp_operand_1,
   output logic [DATA_WIDTH-1:0]    resp_operand_2,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [ADDRESS_WIDTH-1:0] wb_address,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   output logic                     rf_write_enable,
   output logic [ADDRESS_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0]    rf_write_data,
   output logic [ADDRESS_WIDTH-1:0] rf_read_address,
   input  logic [DATA_WIDTH-1:0]    rf_read_data
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(REGISTER_COUNT - 1);
   localparam logic [ADDRESS_WIDTH-1:0] SP_INDEX   = ADDRESS_WIDTH'(STACK_POINTER_INDEX);
   localparam logic [ADDRESS_WIDTH-1:0] X0_INDEX   = ADDRESS_WIDTH'(ZERO_REGISTER);

   state_t                   state_reg, state_next;
   logic [ADDRESS_WIDTH-1:0] counter_reg;
   logic [ADDRESS_WIDTH-1:0] rs1_reg, rs2_reg;
   logic                     use_rs2_reg;
   logic [DATA_WIDTH-1:0]    operand_1_reg, operand_2_reg;
   logic                     init_done_reg, resp_valid_reg;
   logic [DATA_WIDTH-1:0]    bypass_value;

   // One bypass instance serves both read slots; rf_read_address picks the slot.
   operand_bypass #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_operand_bypass (
      .index       (rf_read_address),
      .rf_read_data(rf_read_data),
      .wb_valid    (wb_valid),
      .wb_address  (wb_address),
      .wb_data     (wb_data),
      .operand     (bypass_value)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= INIT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         counter_reg    <= ADDRESS_WIDTH'(1);
         rs1_reg        <= '0;
         rs2_reg        <= '0;
         use_rs2_reg    <= 1'b0;
         operand_1_reg  <= '0;
         operand_2_reg  <= '0;
         init_done_reg  <= 1'b0;
         resp_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               counter_reg <= counter_reg + ADDRESS_WIDTH'(1);
               if (counter_reg == LAST_INDEX) begin
                  init_done_reg <= 1'b1;
               end
            end
            IDLE: begin
               if (req_valid) begin
                  rs1_reg     <= req_rs1;
                  rs2_reg     <= req_rs2;
                  use_rs2_reg <= req_use_rs2;
               end
            end
            READ_1: begin
               operand_1_reg <= bypass_value;
               if (!use_rs2_reg) begin
                  operand_2_reg <= '0;
               end
            end
            READ_2: begin
               operand_2_reg <= bypass_value;
            end
            default: begin
            end
         endcase
         resp_valid_reg <= (state_next == DONE);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         INIT:    if (counter_reg == LAST_INDEX) state_next = IDLE;
         IDLE:    if (req_valid) state_next = READ_1;
         READ_1:  state_next = use_rs2_reg ? READ_2 : DONE;
         READ_2:  state_next = DONE;
         DONE:    if (resp_valid_reg && resp_ready) state_next = IDLE;
         default: state_next = INIT;
      endcase
   end

   always_comb begin
      req_ready        = (state_reg == IDLE);
      wb_ready         = (state_reg != INIT);
      rf_read_address  = '0;
      rf_write_enable  = 1'b0;
      rf_write_address = '0;
      rf_write_data    = '0;
      case (state_reg)
         READ_1:  rf_read_address = rs1_reg;
         READ_2:  rf_read_address = rs2_reg;
         default: rf_read_address = '0;
      endcase
      if (state_reg == INIT) begin
         rf_write_enable  = 1'b1;
         rf_write_address = counter_reg;
         rf_write_data    = (counter_reg == SP_INDEX) ? SP_INIT : '0;
      end else begin
         // Writes to x0 are acknowledged through wb_ready but never reach the array.
         rf_write_enable  = wb_valid && (wb_address != X0_INDEX);
         rf_write_address = wb_address;
         rf_write_data    = wb_data;
      end
   end

   assign init_done      = init_done_reg;
   assign resp_valid     = resp_valid_reg;
   assign resp_operand_1 = operand_1_reg;
   assign resp_operand_2 = operand_2_reg;

endmodule

// File: tb/tb_register_access_controller.sv
// Directed bench for register_access_controller with a behavioural register
// file and a scoreboard of expected operand pairs.
module tb_register_access_controller;

   localparam logic [31:0] SP_VALUE = 32'h0000_1000;

   logic        clock = 1'b0;
   logic        reset;
   logic        init_done;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic        req_use_rs2;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_operand_1;
   logic [31:0] resp_operand_2;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_address;
   logic [31:0] wb_data;
   logic        rf_write_enable;
   logic [4:0]  rf_write_address;
   logic [31:0] rf_write_data;
   logic [4:0]  rf_read_address;
   logic [31:0] rf_read_data;

   logic [31:0] rf_mem [32];

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
   } expect_t;
   expect_t sb_queue [$];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   register_access_controller #(
      .DATA_WIDTH   (32),
      .ADDRESS_WIDTH(5),
      .SP_INIT      (SP_VALUE)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .init_done       (init_done),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rs1         (req_rs1),
      .req_rs2         (req_rs2),
      .req_use_rs2     (req_use_rs2),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_operand_1  (resp_operand_1),
      .resp_operand_2  (resp_operand_2),
      .wb_valid        (wb_valid),
      .wb_ready        (wb_ready),
      .wb_address      (wb_address),
      .wb_data         (wb_data),
      .rf_write_enable (rf_write_enable),
      .rf_write_address(rf_write_address),
      .rf_write_data   (rf_write_data),
      .rf_read_address (rf_read_address),
      .rf_read_data    (rf_read_data)
   );

   // Register file: poisoned contents so the init walk and x0 rule are visible.
   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA5A5_A5A5;
   end
   always @(posedge clock) begin
      if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;
   end
   assign rf_read_data = rf_mem[rf_read_address];

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic run_walk(input string tag);
      for (int i = 1; i <= 31; i++) begin
         check($sformatf("%s_we_%0d", tag, i), 32'(rf_write_enable), 32'd1);
         check($sformatf("%s_wa_%0d", tag, i), 32'(rf_write_address), 32'(i));
         check($sformatf("%s_wd_%0d", tag, i), rf_write_data, (i == 2) ? SP_VALUE : 32'h0);
         check($sformatf("%s_rqr_%0d", tag, i), 32'(req_ready), 32'd0);
         check($sformatf("%s_wbr_%0d", tag, i), 32'(wb_ready), 32'd0);
         check($sformatf("%s_idn_%0d", tag, i), 32'(init_done), 32'd0);
         step();
      end
      check({tag, "_init_done"}, 32'(init_done), 32'd1);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_wb_ready"}, 32'(wb_ready), 32'd1);
      for (int i = 1; i <= 31; i++) begin
         check($sformatf("%s_rf_x%0d", tag, i), rf_mem[i], (i == 2) ? SP_VALUE : 32'h0);
      end
      $display("[TB] %s: init walk complete", tag);
   endtask

   task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
      wb_valid = 1'b1;
      wb_address = addr;
      wb_data = data;
      #1;
      check($sformatf("wb_we_x%0d", addr), 32'(rf_write_enable), 32'(addr != 5'd0));
      check($sformatf("wb_ready_x%0d", addr), 32'(wb_ready), 32'd1);
      step();
      wb_valid = 1'b0;
      $display("[TB] writeback x%0d = %h", addr, data);
   endtask

   task automatic start_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                            input logic [31:0] exp1, input logic [31:0] exp2);
      expect_t e;
      req_valid = 1'b1;
      req_rs1 = rs1;
      req_rs2 = rs2;
      req_use_rs2 = use2;
      #1;
      check("req_ready_at_accept", 32'(req_ready), 32'd1);
      e.op1 = exp1;
      e.op2 = exp2;
      sb_queue.push_back(e);
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int latency);
      int k = 1;
      while (!resp_valid && k < 10) begin
         step();
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(latency));
   endtask

   task automatic complete_resp(input string tag);
      expect_t e;
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_sb_nonempty"}, 32'(sb_queue.size() > 0), 32'd1);
      if (sb_queue.size() > 0) begin
         e = sb_queue.pop_front();
         check({tag, "_op1"}, resp_operand_1, e.op1);
         check({tag, "_op2"}, resp_operand_2, e.op2);
      end
      $display("[TB] %s: op1=%h op2=%h", tag, resp_operand_1, resp_operand_2);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check({tag, "_resp_valid_clr"}, 32'(resp_valid), 32'd0);
      check({tag, "_back_idle"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] held_1;
      logic [31:0] held_2;
      reset = 1'b1;
      req_valid = 1'b0;
      req_rs1 = '0;
      req_rs2 = '0;
      req_use_rs2 = 1'b0;
      resp_ready = 1'b0;
      wb_valid = 1'b0;
      wb_address = '0;
      wb_data = '0;
      repeat (3) step();
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_op1", resp_operand_1, 32'h0);
      check("rst_op2", resp_operand_2, 32'h0);
      reset = 1'b0;
      run_walk("walk1");

      wb_write(5'd5, 32'hDEAD_BEEF);
      wb_write(5'd6, 32'h1234_5678);
      wb_write(5'd7, 32'h0BAD_F00D);

      start_req(5'd5, 5'd6, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      wait_resp("two_reads", 3);
      complete_resp("two_reads");

      start_req(5'd7, 5'd3, 1'b0, 32'h0BAD_F00D, 32'h0);
      wait_resp("one_read", 2);
      held_1 = resp_operand_1;
      held_2 = resp_operand_2;
      req_valid = 1'b1;
      req_rs1 = 5'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold_valid_%0d", i), 32'(resp_valid), 32'd1);
         check($sformatf("hold_req_ready_%0d", i), 32'(req_ready), 32'd0);
         check($sformatf("hold_op1_%0d", i), resp_operand_1, held_1);
         check($sformatf("hold_op2_%0d", i), resp_operand_2, held_2);
      end
      req_valid = 1'b0;
      complete_resp("one_read");

      start_req(5'd9, 5'd0, 1'b0, 32'hCAFE_0001, 32'h0);
      wb_valid = 1'b1;
      wb_address = 5'd9;
      wb_data = 32'hCAFE_0001;
      #1;
      check("bypass_read_addr", 32'(rf_read_address), 32'd9);
      check("bypass_we", 32'(rf_write_enable), 32'd1);
      step();
      wb_valid = 1'b0;
      complete_resp("bypass");
      check("bypass_rf_x9", rf_mem[9], 32'hCAFE_0001);

      wb_write(5'd0, 32'hFFFF_FFFF);
      start_req(5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
      wb_valid = 1'b1;
      wb_address = 5'd0;
      wb_data = 32'hFFFF_FFFF;
      #1;
      check("x0_coincident_we", 32'(rf_write_enable), 32'd0);
      step();
      wb_valid = 1'b0;
      step();
      complete_resp("x0_read");

      start_req(5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait_resp("same_reg", 3);
      complete_resp("same_reg");

      start_req(5'd5, 5'd6, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      step();
      check("midrst_in_read2", 32'(rf_read_address), 32'd6);
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb_queue.delete();
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_counter", 32'(rf_write_address), 32'd1);
      run_walk("walk2");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
